mem_port_arbiter: RTL

- Shares one single-ported, fixed-latency backing memory between two requesters:
  - instruction-cache line refill (cache miss path in fetch);
  - data-memory word read/write (MEM stage).
- Sequences multi-word cache-line bursts and single data accesses.
- Drives a pipeline stall used to gate the hit/enable of the IF_ID, ID_EX, EX_MEM and MEM_WB registers.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle shared by the memory-port arbiter, its two requesters and the backing memory.
// The arbiter uses the slave view; requesters and memory together use the master view.
interface mem_port_arbiter_if #(
   parameter int unsigned LINE_WORDS = 4
);
   localparam int unsigned WordW = $clog2(LINE_WORDS);

   // I-cache refill side
   logic             ic_req;
   logic [31:0]      ic_addr;
   logic             ic_rvalid;
   logic [31:0]      ic_rdata;
   logic [WordW-1:0] ic_word;
   logic             ic_done;

   // Data-memory side
   logic             dm_req;
   logic             dm_we;
   logic [31:0]      dm_addr;
   logic [31:0]      dm_wdata;
   logic [31:0]      dm_rdata;
   logic             dm_done;

   // Backing memory side
   logic             mem_en;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;

   // Pipeline hold
   logic             pipe_stall;

   modport slave (
      input  ic_req, ic_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output ic_rvalid, ic_rdata, ic_word, ic_done, dm_rdata, dm_done,
      output mem_en, mem_we, mem_addr, mem_wdata, pipe_stall
   );

   modport master (
      output ic_req, ic_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  ic_rvalid, ic_rdata, ic_word, ic_done, dm_rdata, dm_done,
      input  mem_en, mem_we, mem_addr, mem_wdata, pipe_stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency, single-ported memory between I-cache line refills and data
// accesses. Round-robin on ties, no preemption, and a pipeline stall while anything is
// pending or in flight.
module mem_port_arbiter #(
   parameter int unsigned LINE_WORDS  = 4,
   parameter int unsigned MEM_LATENCY = 3
) (
   input logic               CLK,
   input logic               RST_N,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned WordW = $clog2(LINE_WORDS);
   localparam int unsigned CntW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   localparam logic [CntW-1:0]  CntLoad     = CntW'(MEM_LATENCY - 1);
   localparam logic [WordW-1:0] LastWord    = WordW'(LINE_WORDS - 1);
   localparam logic [31:0]      LineOffMask = 32'(LINE_WORDS * 4 - 1);

   typedef enum logic [2:0] {
      StIdle,
      StIcIssue,
      StIcWait,
      StDmIssue,
      StDmWait
   } arbStateT;

   arbStateT         stateQ;
   logic [CntW-1:0]  waitCntQ;
   logic [WordW-1:0] wordIdxQ;
   logic             rrLastDmQ;  // 1: last grant went to DM, 0: to IC
   logic             dmWeQ;

   logic icReqM;
   logic dmReqM;
   logic grantDm;
   logic grantIc;

   // Mask the side whose done pulse is showing, pick a winner, and form the stall.
   always_comb begin
      icReqM         = bus.ic_req & ~bus.ic_done;
      dmReqM         = bus.dm_req & ~bus.dm_done;
      grantDm        = dmReqM & (~icReqM | ~rrLastDmQ);
      grantIc        = icReqM & ~grantDm;
      bus.pipe_stall = (stateQ != StIdle) | icReqM | dmReqM;
   end

   // Arbitration FSM with registered memory strobes and requester responses.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stateQ        <= StIdle;
         waitCntQ      <= '0;
         wordIdxQ      <= '0;
         rrLastDmQ     <= 1'b0;
         dmWeQ         <= 1'b0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.ic_rvalid <= 1'b0;
         bus.ic_rdata  <= '0;
         bus.ic_word   <= '0;
         bus.ic_done   <= 1'b0;
         bus.dm_rdata  <= '0;
         bus.dm_done   <= 1'b0;
      end else begin
         // Strobes and pulses are single-cycle unless re-armed below.
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.ic_rvalid <= 1'b0;
         bus.ic_done   <= 1'b0;
         bus.dm_done   <= 1'b0;
         case (stateQ)
            StIdle: begin
               if (grantDm) begin
                  stateQ        <= StDmIssue;
                  rrLastDmQ     <= 1'b1;
                  dmWeQ         <= bus.dm_we;
                  bus.mem_en    <= 1'b1;
                  bus.mem_we    <= bus.dm_we;
                  bus.mem_addr  <= bus.dm_addr & 32'hFFFF_FFFC;
                  bus.mem_wdata <= bus.dm_wdata;
               end else if (grantIc) begin
                  stateQ       <= StIcIssue;
                  rrLastDmQ    <= 1'b0;
                  wordIdxQ     <= '0;
                  bus.mem_en   <= 1'b1;
                  bus.mem_addr <= bus.ic_addr & ~LineOffMask;
               end
            end
            StIcIssue: begin
               stateQ   <= StIcWait;
               waitCntQ <= CntLoad;
            end
            StIcWait: begin
               if (waitCntQ != '0) begin
                  waitCntQ <= waitCntQ - CntW'(1);
               end else begin
                  bus.ic_rvalid <= 1'b1;
                  bus.ic_rdata  <= bus.mem_rdata;
                  bus.ic_word   <= wordIdxQ;
                  if (wordIdxQ == LastWord) begin
                     stateQ      <= StIdle;
                     bus.ic_done <= 1'b1;
                  end else begin
                     // Next word issues in the same cycle the previous one is delivered.
                     stateQ       <= StIcIssue;
                     wordIdxQ     <= wordIdxQ + WordW'(1);
                     bus.mem_en   <= 1'b1;
                     bus.mem_addr <= bus.mem_addr + 32'd4;
                  end
               end
            end
            StDmIssue: begin
               stateQ   <= StDmWait;
               waitCntQ <= CntLoad;
            end
            StDmWait: begin
               if (waitCntQ != '0) begin
                  waitCntQ <= waitCntQ - CntW'(1);
               end else begin
                  stateQ      <= StIdle;
                  bus.dm_done <= 1'b1;
                  if (!dmWeQ) begin
                     bus.dm_rdata <= bus.mem_rdata;
                  end
               end
            end
            default: stateQ <= StIdle;
         endcase
      end
   end
endmodule
